pcs_block_lock: RTL and testbench

//  Receive-side 64b/66b block-lock controller (IEEE 802.3 Cl.49 style) for the 10G PCS.
//  - Checks each 2-bit sync header from the RX gearbox.
//  - Issues bit-slip requests to the gearbox until 64 consecutive valid headers are seen.
//  - Drops lock on excessive invalid headers.
//  - Sequences the descrambler by gating its data-valid while unlocked.

---
 rtl/pcs_block_lock.sv | 177 +++++++++++++++++
 tb/tb_pcs_block_lock.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pcs_block_lock.sv
// Receive-side 64b/66b block-lock controller: sync-header check, gearbox bit-slip and descrambler gating.
// Optional high-BER monitor is built only when BER_MONITOR_EN is defined; otherwise hi_ber is tied 0.
module pcs_block_lock #(
   parameter int LOCK_CNT    = 64,
   parameter int INVALID_MAX = 16,
   parameter int SLIP_WAIT   = 4
`ifdef BER_MONITOR_EN
   ,
   parameter int BER_WINDOW  = 19531,
   parameter int BER_THRESH  = 16
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] in_header,
   input  logic       in_header_valid,
   output logic       slip,
   output logic       block_lock,
   output logic       descr_valid,
   output logic [7:0] slip_count,
   output logic       hi_ber
);

   localparam int CNT_W  = $clog2(LOCK_CNT + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

   localparam logic [CNT_W-1:0]  SH_LAST   = CNT_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0]  INV_LAST  = CNT_W'(INVALID_MAX - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

   typedef enum logic [1:0] {
      S_RESET_CNT,
      S_TEST,
      S_SLIP,
      S_WAIT
   } state_t;

   state_t              r_state,      w_state_nxt;
   logic [CNT_W-1:0]    r_sh_cnt,     w_sh_cnt_nxt;
   logic [CNT_W-1:0]    r_inv_cnt,    w_inv_cnt_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt,   w_wait_cnt_nxt;
   logic                r_block_lock, w_block_lock_nxt;
   logic [7:0]          r_slip_count, w_slip_count_nxt;

   logic w_hdr_ok;
   logic w_hdr_bad;

   // Only 01 and 10 are legal sync headers.
   assign w_hdr_ok  = in_header[1] ^ in_header[0];
   assign w_hdr_bad = in_header_valid & ~w_hdr_ok;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_RESET_CNT;
         r_sh_cnt     <= '0;
         r_inv_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_block_lock <= 1'b0;
         r_slip_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_sh_cnt     <= w_sh_cnt_nxt;
         r_inv_cnt    <= w_inv_cnt_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_block_lock <= w_block_lock_nxt;
         r_slip_count <= w_slip_count_nxt;
      end
   end

   // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_sh_cnt_nxt     = r_sh_cnt;
      w_inv_cnt_nxt    = r_inv_cnt;
      w_wait_cnt_nxt   = r_wait_cnt;
      w_block_lock_nxt = r_block_lock;
      w_slip_count_nxt = r_slip_count;

      case (r_state)
         S_RESET_CNT: begin
            w_sh_cnt_nxt  = '0;
            w_inv_cnt_nxt = '0;
            w_state_nxt   = S_TEST;
         end

         S_TEST: begin
            if (in_header_valid) begin
               if (!r_block_lock) begin
                  if (!w_hdr_ok) begin
                     w_state_nxt = S_SLIP;
                  end else if (r_sh_cnt == SH_LAST) begin
                     w_block_lock_nxt = 1'b1;
                     w_state_nxt      = S_RESET_CNT;
                  end else begin
                     w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                  end
               end else begin
                  w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                  if (!w_hdr_ok) begin
                     w_inv_cnt_nxt = r_inv_cnt + 1'b1;
                  end
                  // Loss of lock wins over a coincident window end.
                  if (!w_hdr_ok && (r_inv_cnt == INV_LAST)) begin
                     w_block_lock_nxt = 1'b0;
                     w_state_nxt      = S_SLIP;
                  end else if (r_sh_cnt == SH_LAST) begin
                     w_state_nxt = S_RESET_CNT;
                  end
               end
            end
         end

         S_SLIP: begin
            if (r_slip_count != 8'hFF) begin
               w_slip_count_nxt = r_slip_count + 1'b1;
            end
            w_wait_cnt_nxt = '0;
            w_state_nxt    = S_WAIT;
         end

         S_WAIT: begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            if (r_wait_cnt == WAIT_LAST) begin
               w_state_nxt = S_RESET_CNT;
            end
         end

         default: begin
            w_state_nxt = S_RESET_CNT;
         end
      endcase
   end

   assign slip        = (r_state == S_SLIP);
   assign block_lock  = r_block_lock;
   assign descr_valid = in_header_valid & r_block_lock;
   assign slip_count  = r_slip_count;

`ifdef BER_MONITOR_EN
   localparam int WIN_W = $clog2(BER_WINDOW);
   localparam int BER_W = $clog2(BER_THRESH + 1);

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
   localparam logic [BER_W-1:0] BER_LIM  = BER_W'(BER_THRESH);

   logic [WIN_W-1:0] r_win_cnt;
   logic [BER_W-1:0] r_ber_cnt;
   logic             r_hi_ber;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_cnt <= '0;
         r_ber_cnt <= '0;
         r_hi_ber  <= 1'b0;
      end else if (r_win_cnt == WIN_LAST) begin
         // A bad header on the closing cycle is charged to the window that starts now.
         r_win_cnt <= '0;
         r_hi_ber  <= (r_ber_cnt >= BER_LIM);
         r_ber_cnt <= w_hdr_bad ? BER_W'(1) : '0;
      end else begin
         r_win_cnt <= r_win_cnt + 1'b1;
         if (r_ber_cnt == BER_LIM) begin
            r_hi_ber <= 1'b1;
         end
         if (w_hdr_bad && (r_ber_cnt != BER_LIM)) begin
            r_ber_cnt <= r_ber_cnt + 1'b1;
         end
      end
   end

   assign hi_ber = r_hi_ber;
`else
   assign hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_block_lock.sv
// Directed bench for pcs_block_lock: acquisition, slip/wait, locked-window loss, gated valid, reset, BER flag.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pcs_block_lock;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_header = 2'b00;
   logic       in_header_valid = 1'b0;
   logic       slip;
   logic       block_lock;
   logic       descr_valid;
   logic [7:0] slip_count;
   logic       hi_ber;

   int   n_checks = 0;
   int   n_fail = 0;
   int   n_edge = 0;
   logic slip_seen = 1'b0;

   always #5 clk = ~clk;

   pcs_block_lock #(
`ifdef BER_MONITOR_EN
      .BER_WINDOW (100),
      .BER_THRESH (16),
`endif
      .LOCK_CNT   (64),
      .INVALID_MAX(16),
      .SLIP_WAIT  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_header      (in_header),
      .in_header_valid(in_header_valid),
      .slip           (slip),
      .block_lock     (block_lock),
      .descr_valid    (descr_valid),
      .slip_count     (slip_count),
      .hi_ber         (hi_ber)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One clock with the given header; returns just after the edge.
   task automatic drive(input logic [1:0] h, input logic v);
      in_header       = h;
      in_header_valid = v;
      @(posedge clk);
      #1;
      n_edge++;
      slip_seen = slip_seen | slip;
   endtask

   task automatic drive_n(input logic [1:0] h, input logic v, input int n);
      for (int i = 0; i < n; i++) drive(h, v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic exp_ber;
`ifdef BER_MONITOR_EN
      exp_ber = 1'b1;
`else
      exp_ber = 1'b0;
`endif
      // Reset state
      #2;
      check("rst_slip",        32'(slip),        0);
      check("rst_block_lock",  32'(block_lock),  0);
      check("rst_descr_valid", 32'(descr_valid), 0);
      check("rst_slip_count",  32'(slip_count),  0);
      check("rst_hi_ber",      32'(hi_ber),      0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_edge = 0;
      drive(2'b00, 1'b0);                    // RESET_CNT cycle

      // 1: 64 consecutive valid headers acquire lock
      slip_seen = 1'b0;
      in_header = 2'b01;
      in_header_valid = 1'b1;
      #1;
      check("t1_descr_unlocked", 32'(descr_valid), 0);
      for (int i = 0; i < 64; i++) begin
         drive(2'b01, 1'b1);
         if (i == 62) check("t1_lock_after_63", 32'(block_lock), 0);
      end
      check("t1_lock_after_64", 32'(block_lock), 1);
      check("t1_no_slip",       32'(slip_seen),  0);
      check("t1_slip_count",    32'(slip_count), 0);
      in_header_valid = 1'b1;
      #1;
      check("t1_descr_on",  32'(descr_valid), 1);
      in_header_valid = 1'b0;
      #1;
      check("t1_descr_off", 32'(descr_valid), 0);
      drive(2'b00, 1'b0);                    // RESET_CNT

      // 3: 15 invalid in a window keeps lock; 16 in the next loses it
      slip_seen = 1'b0;
      for (int i = 0; i < 64; i++) drive((i < 15) ? 2'b11 : 2'b01, 1'b1);
      check("t3_lock_15_bad", 32'(block_lock), 1);
      check("t3_no_slip_15",  32'(slip_seen),  0);
      drive(2'b00, 1'b0);                    // RESET_CNT
      for (int i = 0; i < 16; i++) begin
         drive(2'b11, 1'b1);
         if (i == 14) check("t3_lock_at_15th", 32'(block_lock), 1);
      end
      check("t3_lock_lost", 32'(block_lock), 0);
      check("t3_slip",      32'(slip),       1);
      drive(2'b11, 1'b1);
      check("t3_slip_one_cycle", 32'(slip),       0);
      check("t3_slip_count",     32'(slip_count), 1);
      slip_seen = 1'b0;
      drive_n(2'b11, 1'b1, 5);               // WAIT x4, RESET_CNT
      check("t3_wait_ignored", 32'(slip_seen), 0);

      // 2: unlocked, bad header #10 slips; fresh 64 needed
      for (int i = 0; i < 10; i++) drive((i == 9) ? 2'b11 : 2'b01, 1'b1);
      check("t2_slip",       32'(slip),       1);
      check("t2_still_unlk", 32'(block_lock), 0);
      drive(2'b11, 1'b1);
      check("t2_slip_count", 32'(slip_count), 2);
      slip_seen = 1'b0;
      drive_n(2'b11, 1'b1, 5);
      check("t2_wait_ignored", 32'(slip_seen), 0);
      drive_n(2'b01, 1'b1, 63);
      check("t2_lock_after_63", 32'(block_lock), 0);
      drive(2'b01, 1'b1);
      check("t2_lock_after_64", 32'(block_lock), 1);
      drive(2'b00, 1'b0);                    // RESET_CNT

      // 4: 16th invalid on header #64 of the window loses lock
      drive_n(2'b01, 1'b1, 48);
      drive_n(2'b11, 1'b1, 15);
      check("t4_lock_at_63", 32'(block_lock), 1);
      check("t4_no_slip_63", 32'(slip),       0);
      drive(2'b11, 1'b1);
      check("t4_lock_lost", 32'(block_lock), 0);
      check("t4_slip",      32'(slip),       1);
      drive(2'b00, 1'b0);
      check("t4_slip_count", 32'(slip_count), 3);
      drive_n(2'b00, 1'b0, 5);               // WAIT runs without valid headers

      // 5: valid toggled 50%, invalid headers on non-valid cycles ignored
      slip_seen = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         drive(2'b11, 1'b0);
         drive(2'b01, 1'b1);
         if (k == 63) check("t5_lock_after_63", 32'(block_lock), 0);
      end
      check("t5_lock_after_64", 32'(block_lock), 1);
      check("t5_no_slip",       32'(slip_seen),  0);
      drive(2'b00, 1'b0);                    // RESET_CNT
      drive_n(2'b11, 1'b1, 16);
      check("t5_lock_lost", 32'(block_lock), 0);
      drive(2'b00, 1'b0);
      drive(2'b00, 1'b0);                    // mid-WAIT
      check("t5_slip_count", 32'(slip_count), 4);
      in_header_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("t5_rst_slip_count", 32'(slip_count),  0);
      check("t5_rst_lock",       32'(block_lock),  0);
      check("t5_rst_slip",       32'(slip),        0);
      check("t5_rst_descr",      32'(descr_valid), 0);
      in_header_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_edge = 0;

      // 6: BER window of 100 cycles
      drive_n(2'b11, 1'b1, 16);
      check("t6_hi_ber_not_yet", 32'(hi_ber), 0);
      drive(2'b00, 1'b0);
      check("t6_hi_ber_set", 32'(hi_ber), 32'(exp_ber));
      while (n_edge < 199) drive(2'b00, 1'b0);
      check("t6_hi_ber_held", 32'(hi_ber), 32'(exp_ber));
      drive(2'b00, 1'b0);
      check("t6_hi_ber_clear", 32'(hi_ber), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
